fpu_cvt_arb: RTL and testbench



---
 rtl/fpu_cvt_arb_pkg.sv | 21 ++
 rtl/fpu_cvt_arb_if.sv | 29 ++
 rtl/fpu_cvt_retq.sv | 42 ++++
 rtl/fpu_cvt_arb.sv | 98 +++++++++
 tb/tb_fpu_cvt_arb.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_cvt_arb_pkg.sv
// fpu_cvt_arb_pkg: shared FP convert constants, defaults, return entry type and lane helpers
package fpu_cvt_arb_pkg;
  localparam logic [7:0] fop_pcvtD = 8'h3c;
  localparam logic [7:0] fop_pcvtS = 8'h3d;
  localparam int LAT_DEF = 2;
  localparam int DEPTH_DEF = 4;
  localparam int TAGW_DEF = 9;
  localparam int DATAW = 68;
  typedef struct packed {
    logic [1:0]          lane;
    logic [TAGW_DEF-1:0] tag;
    logic [DATAW-1:0]    data;
    logic                alt;
  } ret_entry_t;
  function automatic logic [1:0] lane_next(input logic [1:0] l);
    return (l == 2'd2) ? 2'd0 : l + 2'd1;
  endfunction
  function automatic logic [2:0] lane_oh(input logic [1:0] l);
    return 3'b001 << l;
  endfunction
endpackage

// File: rtl/fpu_cvt_arb_if.sv
// fpu_cvt_arb_if: issue-lane, converter and writeback signals of the shared convert pipe
interface fpu_cvt_arb_if import fpu_cvt_arb_pkg::*; #(parameter int TAGW = TAGW_DEF) ();
  logic                flush;
  logic [2:0]          req_valid;
  logic [2:0]          req_ready;
  logic [2:0]          req_dbl;
  logic [3*DATAW-1:0]  req_data;
  logic [3*TAGW-1:0]   req_tag;
  logic                cvt_en;
  logic [DATAW-1:0]    cvt_A;
  logic                cvt_isDBL;
  logic                cvt_is32b;
  logic [DATAW-1:0]    cvt_res;
  logic                cvt_alt;
  logic [2:0]          ret_valid;
  logic [DATAW-1:0]    ret_data;
  logic [TAGW-1:0]     ret_tag;
  logic                ret_alt;
  logic [2:0]          ret_accept;
  logic                busy;
  modport master (
    output flush, req_valid, req_dbl, req_data, req_tag, cvt_res, cvt_alt, ret_accept,
    input  req_ready, cvt_en, cvt_A, cvt_isDBL, cvt_is32b, ret_valid, ret_data, ret_tag, ret_alt, busy
  );
  modport slave (
    input  flush, req_valid, req_dbl, req_data, req_tag, cvt_res, cvt_alt, ret_accept,
    output req_ready, cvt_en, cvt_A, cvt_isDBL, cvt_is32b, ret_valid, ret_data, ret_tag, ret_alt, busy
  );
endinterface

// File: rtl/fpu_cvt_retq.sv
// fpu_cvt_retq: shifting sync FIFO whose head always sits in entry 0 so dout comes straight from a register
module fpu_cvt_retq #(
  parameter int DEPTH = 4,
  parameter int W = 80
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] mem_n [DEPTH];
  logic [AW-1:0] wr_idx;
  assign wr_idx = AW'(count - CW'(pop));
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[0];
  always_comb begin
    mem_n = mem;
    if (pop) for (int i = 0; i < DEPTH - 1; i++) mem_n[i] = mem[i + 1];
    if (push) mem_n[wr_idx] = din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      mem <= mem_n;
    end
  end
endmodule

// File: rtl/fpu_cvt_arb.sv
// fpu_cvt_arb: round-robin arbiter, credit tracker and in-order result return for the shared FP-to-int convert pipe
module fpu_cvt_arb import fpu_cvt_arb_pkg::*; #(
  parameter int LAT = LAT_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int TAGW = TAGW_DEF
) (
  input logic          clk,
  input logic          rst,
  fpu_cvt_arb_if.slave io
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 2 + TAGW + DATAW + 1;
  typedef struct packed {
    logic [1:0]       lane;
    logic [TAGW-1:0]  tag;
    logic [DATAW-1:0] data;
    logic             alt;
  } ent_t;
  typedef struct packed {
    logic            v;
    logic [1:0]      lane;
    logic [TAGW-1:0] tag;
  } stg_t;
  logic [1:0] rr, c1, c2, win;
  logic [CW-1:0] cnt, q_cnt;
  logic allow, grant, push, pop, q_full, q_empty, dbl_q;
  logic [DATAW-1:0] a_q, win_data;
  logic [TAGW-1:0] win_tag;
  stg_t s0, tail;
  ent_t head;
  always_comb begin
    c1 = lane_next(rr);
    c2 = lane_next(c1);
    win = io.req_valid[rr] ? rr : io.req_valid[c1] ? c1 : c2;
    allow = !rst && !io.flush && cnt < CW'(DEPTH);
    grant = allow && |io.req_valid;
    win_data = win == 2'd0 ? io.req_data[67:0] : win == 2'd1 ? io.req_data[135:68] : io.req_data[203:136];
    win_tag = win == 2'd0 ? io.req_tag[TAGW-1:0] : win == 2'd1 ? io.req_tag[2*TAGW-1:TAGW] : io.req_tag[3*TAGW-1:2*TAGW];
    s0 = {grant, win, win_tag};
  end
  assign io.req_ready = grant ? lane_oh(win) : 3'b000;
  assign io.cvt_en = grant;
  assign io.cvt_A = grant ? win_data : a_q;
  assign io.cvt_isDBL = grant ? io.req_dbl[win] : dbl_q;
  assign io.cvt_is32b = !io.cvt_isDBL;
  assign io.busy = cnt != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= 2'd0;
      cnt <= '0;
      a_q <= '0;
      dbl_q <= 1'b0;
    end else begin
      if (grant) begin
        rr <= lane_next(win);
        a_q <= win_data;
        dbl_q <= io.req_dbl[win];
      end
      cnt <= io.flush ? '0 : cnt + CW'(grant) - CW'(pop);
    end
  end
  // stage 0 is the issue cycle itself; registered stages carry the op until the converter result lines up
  if (LAT == 1) begin : g_direct
    assign tail = s0;
  end else begin : g_pipe
    stg_t pq [LAT-1];
    always_ff @(posedge clk) begin
      if (rst || io.flush) begin
        for (int i = 0; i < LAT - 1; i++) pq[i] <= '0;
      end else begin
        pq[0] <= s0;
        for (int i = 1; i < LAT - 1; i++) pq[i] <= pq[i-1];
      end
    end
    assign tail = pq[LAT-2];
  end
  assign push = tail.v;
  assign pop = !q_empty && io.ret_accept[head.lane];
  fpu_cvt_retq #(.DEPTH(DEPTH), .W(EW)) u_retq (
    .clk(clk),
    .rst(rst),
    .clr(io.flush),
    .push(push),
    .din({tail.lane, tail.tag, io.cvt_res, io.cvt_alt}),
    .pop(pop),
    .dout(head),
    .count(q_cnt),
    .full(q_full),
    .empty(q_empty)
  );
  assign io.ret_valid = q_empty ? 3'b000 : lane_oh(head.lane);
  assign io.ret_data = head.data;
  assign io.ret_tag = head.tag;
  assign io.ret_alt = head.alt;
  // credits cover every buffered entry, so the queue can never be asked to overfill
  assert property (@(posedge clk) disable iff (rst) !(push && q_full && !pop));
  assert property (@(posedge clk) disable iff (rst) q_cnt <= cnt);
endmodule

// File: tb/tb_fpu_cvt_arb.sv
// tb_fpu_cvt_arb: scoreboard bench with a behavioural converter for fpu_cvt_arb
module tb_fpu_cvt_arb;
  typedef struct {
    logic [1:0]  lane;
    logic [8:0]  tag;
    logic [67:0] data;
    logic        alt;
  } exp_t;
  logic clk, rst;
  logic s_rst, s_flush;
  logic [2:0] s_valid, s_dbl, s_acc;
  logic [67:0] ld [3];
  logic [8:0] lt [3];
  exp_t sb [$];
  int total, bad, n;
  fpu_cvt_arb_if #(.TAGW(9)) io ();
  fpu_cvt_arb #(.LAT(2), .DEPTH(4), .TAGW(9)) dut (.clk(clk), .rst(rst), .io(io.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [67:0] cf(input logic [67:0] a, input logic d);
    return a == 68'h3FF0_0000_0000_0000 ? 68'h1 : (a ^ 68'hFFFF_0000) + 68'(d);
  endfunction
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic observe();
    exp_t e;
    logic [2:0] g;
    if (rst || io.flush) begin
      sb.delete();
    end else begin
      if (io.ret_valid != 3'b000) begin
        if (sb.size() == 0) chk("ret_unexp", io.ret_valid, 0);
        else begin
          e = sb[0];
          chk("ret_lane", io.ret_valid, 3'b001 << e.lane);
          chk("ret_tag", io.ret_tag, e.tag);
          chk("ret_data", io.ret_data, e.data);
          chk("ret_alt", io.ret_alt, e.alt);
          if (io.ret_accept[e.lane]) void'(sb.pop_front());
        end
      end
      g = io.req_valid & io.req_ready;
      for (int i = 0; i < 3; i++)
        if (g[i]) sb.push_back('{lane: 2'(i), tag: lt[i], data: cf(ld[i], s_dbl[i]), alt: ^ld[i][7:0]});
    end
  endtask
  task automatic step();
    @(negedge clk);
    rst = s_rst;
    io.flush = s_flush;
    io.req_valid = s_valid;
    io.req_dbl = s_dbl;
    io.req_data = {ld[2], ld[1], ld[0]};
    io.req_tag = {lt[2], lt[1], lt[0]};
    io.ret_accept = s_acc;
    #1;
    observe();
  endtask
  task automatic rnd_lanes();
    for (int i = 0; i < 3; i++) begin
      ld[i] = {4'($urandom), $urandom, $urandom};
      lt[i] = 9'($urandom);
    end
    s_dbl = 3'($urandom);
  endtask
  // converter model: result for an op issued in cycle T is presented during cycle T+1
  initial begin
    logic cv, ca;
    logic [67:0] cr;
    io.cvt_res = 68'hBAD;
    io.cvt_alt = 1'b1;
    forever begin
      @(negedge clk);
      #2;
      cv = io.cvt_en;
      cr = cf(io.cvt_A, io.cvt_isDBL);
      ca = ^io.cvt_A[7:0];
      @(posedge clk);
      #1;
      io.cvt_res = cv ? cr : 68'hBAD;
      io.cvt_alt = cv ? ca : 1'b1;
    end
  end
  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    s_rst = 1'b1;
    s_flush = 1'b0;
    s_valid = 3'b000;
    s_dbl = 3'b000;
    s_acc = 3'b000;
    for (int i = 0; i < 3; i++) begin
      ld[i] = '0;
      lt[i] = '0;
    end
    repeat (2) step();
    s_rst = 1'b0;
    step();
    chk("rst_rdy", io.req_ready, 0);
    chk("rst_en", io.cvt_en, 0);
    chk("rst_A", io.cvt_A, 0);
    chk("rst_dbl", io.cvt_isDBL, 0);
    chk("rst_rv", io.ret_valid, 0);
    chk("rst_data", io.ret_data, 0);
    chk("rst_tag", io.ret_tag, 0);
    chk("rst_alt", io.ret_alt, 0);
    chk("rst_busy", io.busy, 0);
    ld[1] = 68'h3FF0_0000_0000_0000;
    lt[1] = 9'd5;
    s_dbl = 3'b010;
    s_valid = 3'b010;
    s_acc = 3'b010;
    step();
    chk("one_rdy", io.req_ready, 3'b010);
    chk("one_en", io.cvt_en, 1);
    chk("one_A", io.cvt_A, 68'h3FF0_0000_0000_0000);
    chk("one_dbl", io.cvt_isDBL, 1);
    chk("one_32b", io.cvt_is32b, 0);
    s_valid = 3'b000;
    step();
    chk("one_early", io.ret_valid, 0);
    chk("one_busy1", io.busy, 1);
    step();
    chk("one_rv", io.ret_valid, 3'b010);
    chk("one_data", io.ret_data, 1);
    chk("one_tag", io.ret_tag, 5);
    step();
    chk("one_busy0", io.busy, 0);
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    s_valid = 3'b111;
    s_acc = 3'b111;
    for (int i = 0; i < 12; i++) begin
      rnd_lanes();
      step();
      chk("rr_grant", io.req_ready, 3'b001 << (i % 3));
    end
    s_valid = 3'b000;
    repeat (4) step();
    chk("rr_busy", io.busy, 0);
    s_acc = 3'b000;
    s_valid = 3'b001;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      rnd_lanes();
      step();
      n += int'(io.req_ready[0]);
    end
    chk("bp_grants", n, 4);
    chk("bp_full_rdy", io.req_ready, 0);
    s_acc = 3'b001;
    step();
    chk("bp_pulse_rdy", io.req_ready, 0);
    s_acc = 3'b000;
    rnd_lanes();
    step();
    chk("bp_regrant", io.req_ready, 3'b001);
    step();
    chk("bp_refull", io.req_ready, 0);
    s_valid = 3'b000;
    s_acc = 3'b111;
    repeat (8) step();
    chk("bp_busy", io.busy, 0);
    s_acc = 3'b000;
    s_valid = 3'b100;
    rnd_lanes();
    lt[2] = 9'h1A5;
    step();
    s_valid = 3'b000;
    repeat (2) step();
    chk("wl_head", io.ret_valid, 3'b100);
    s_acc = 3'b001;
    step();
    chk("wl_hold_rv", io.ret_valid, 3'b100);
    chk("wl_hold_tag", io.ret_tag, 9'h1A5);
    step();
    chk("wl_hold_busy", io.busy, 1);
    s_acc = 3'b100;
    step();
    step();
    chk("wl_pop", io.ret_valid, 0);
    chk("wl_busy", io.busy, 0);
    s_acc = 3'b000;
    s_valid = 3'b001;
    repeat (3) begin
      rnd_lanes();
      step();
    end
    s_flush = 1'b1;
    step();
    chk("fl_rdy", io.req_ready, 0);
    chk("fl_en", io.cvt_en, 0);
    s_flush = 1'b0;
    s_valid = 3'b000;
    step();
    chk("fl_rv", io.ret_valid, 0);
    chk("fl_busy", io.busy, 0);
    repeat (2) begin
      step();
      chk("fl_late", io.ret_valid, 0);
    end
    s_valid = 3'b010;
    rnd_lanes();
    step();
    chk("fl_next", io.req_ready, 3'b010);
    s_valid = 3'b000;
    s_acc = 3'b111;
    repeat (4) step();
    chk("fl_drain", io.busy, 0);
    s_acc = 3'b000;
    s_valid = 3'b010;
    rnd_lanes();
    step();
    s_valid = 3'b100;
    rnd_lanes();
    step();
    s_valid = 3'b010;
    rnd_lanes();
    step();
    s_valid = 3'b000;
    repeat (2) step();
    chk("rm_q", io.ret_valid, 3'b010);
    s_rst = 1'b1;
    s_valid = 3'b101;
    step();
    s_rst = 1'b0;
    rnd_lanes();
    step();
    chk("rm_rdy", io.req_ready, 3'b001);
    chk("rm_rv", io.ret_valid, 0);
    chk("rm_busy", io.busy, 0);
    chk("rm_data", io.ret_data, 0);
    chk("rm_tag", io.ret_tag, 0);
    chk("rm_alt", io.ret_alt, 0);
    s_valid = 3'b000;
    s_acc = 3'b111;
    repeat (4) step();
    chk("rm_drain", io.busy, 0);
    chk("sb_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
